// File: rtl/ir_pkg.sv
// Shared definitions for the instruction buffer: FSM state encoding and
// default width constants used by ir_buffer and ir_ram.
package ir_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 4;
    localparam int MEM_ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_WORK = 2'd2
    } ir_state_e;

endpackage

// File: rtl/ir_ram.sv
// Entry storage: DEPTH x DATA_W array with one synchronous write port and
// one registered read port (read-before-write on an address collision).
module ir_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ir_buffer.sv
// Instruction buffer: fills all entries from backing memory after INIT, then
// serves single-cycle-latency reads and writes in WORK until a reload.
module ir_buffer
    import ir_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MEM_ADDR_W-1:0] base_addr,
    input  logic                  reload,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  ready,
    output logic                  load_done,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid
);

    ir_state_e             state;
    logic [ADDR_W-1:0]     cnt;
    logic [MEM_ADDR_W-1:0] base_q;

    logic              load_ack;
    logic              work_wr;
    logic              work_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // A stray ack with no request outstanding, or any ack in a reset cycle, never writes.
    assign load_ack  = (state == ST_LOAD) && mem_req && mem_ack;
    assign work_wr   = (state == ST_WORK) && wr_en;
    assign work_rd   = (state == ST_WORK) && rd_en;
    assign ram_we    = rst_n && (load_ack || work_wr);
    assign ram_waddr = load_ack ? cnt : wr_addr;
    assign ram_wdata = load_ack ? mem_rdata : wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ready     <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    base_q   <= base_addr;
                    cnt      <= '0;
                    mem_req  <= 1'b1;
                    mem_addr <= base_addr;
                    state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (mem_req && mem_ack) begin
                        cnt      <= cnt + ADDR_W'(1);
                        mem_addr <= base_q + MEM_ADDR_W'(cnt) + MEM_ADDR_W'(1);
                        if (cnt == '1) begin
                            state     <= ST_WORK;
                            mem_req   <= 1'b0;
                            ready     <= 1'b1;
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_WORK: begin
                    if (reload) begin
                        state <= ST_INIT;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_INIT;
                    mem_req <= 1'b0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= work_rd;
        end
    end

    ir_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (work_rd),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ir_buffer.sv
// Self-checking bench for ir_buffer: directed load/reset/reload scenarios plus
// randomized traffic compared against an array model of the entries.
module tb_ir_buffer;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int MW    = 16;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [MW-1:0] base_addr;
    logic          reload;
    logic          mem_req;
    logic [MW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          ready;
    logic          load_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rd;

    ir_buffer #(.DATA_W(DW), .ADDR_W(AW), .MEM_ADDR_W(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_addr (base_addr),
        .reload    (reload),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ready     (ready),
        .load_done (load_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side_inputs();
        reload = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
    endtask

    // Memory responder + expected address sequence: word k lives at base+k (16-bit wrap).
    task automatic do_load(input logic [MW-1:0] base, input int period, input bit addr_data,
                           input int n_acks, input bit noise);
        int k;
        int cyc;
        int wait_c;
        logic [MW-1:0] ea;
        k = 0;
        cyc = 0;
        wait_c = 0;
        while (!mem_req && wait_c < 5) begin
            step();
            wait_c++;
        end
        check("load_start_req", mem_req, 1);
        while (k < n_acks && cyc < 400) begin
            ea = base + MW'(k);
            check("load_mem_req", mem_req, 1);
            check("load_mem_addr", mem_addr, ea);
            check("load_ready", ready, 0);
            check("load_done_low", load_done, 0);
            check("load_rd_valid", rd_valid, 0);
            mem_ack   = ((cyc % period) == period - 1);
            mem_rdata = addr_data ? DW'(ea) : $urandom;
            if (noise) begin
                reload  = $urandom_range(0, 1);
                rd_en   = $urandom_range(0, 1);
                rd_addr = AW'($urandom);
                wr_en   = $urandom_range(0, 1);
                wr_addr = AW'($urandom);
                wr_data = $urandom;
            end
            if (mem_ack) begin
                model[k] = mem_rdata;
                k++;
            end
            step();
            cyc++;
        end
        mem_ack = 1'b0;
        clear_side_inputs();
        if (k < n_acks) check("load_timeout", k, n_acks);
        if (n_acks == DEPTH) begin
            check("done_mem_req", mem_req, 0);
            check("done_pulse", load_done, 1);
            check("done_ready", ready, 1);
            check("done_rd_valid", rd_valid, 0);
            step();
            check("done_pulse_end", load_done, 0);
            check("done_ready_hold", ready, 1);
        end
    endtask

    task automatic read_entry(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        step();
        rd_en = 1'b0;
        last_rd = model[a];
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, last_rd);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) read_entry(a);
    endtask

    task automatic work_random(input int n);
        logic          prev_rd;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < n; i++) begin
            rd_en     = $urandom_range(0, 1);
            rd_addr   = AW'($urandom);
            wr_en     = $urandom_range(0, 1);
            wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom);
            wr_data   = $urandom;
            mem_ack   = $urandom_range(0, 1);
            mem_rdata = $urandom;
            prev_rd   = rd_en;
            exp_d     = model[rd_addr];
            if (wr_en) model[wr_addr] = wr_data;
            step();
            if (prev_rd) last_rd = exp_d;
            check("rand_ready", ready, 1);
            check("rand_rd_valid", rd_valid, prev_rd);
            check("rand_rd_data", rd_data, last_rd);
            check("rand_mem_req", mem_req, 0);
        end
        clear_side_inputs();
        mem_ack = 1'b0;
        step();
        check("rand_rd_valid_idle", rd_valid, 0);
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        logic [MW-1:0] rbase;
        rst_n     = 1'b0;
        base_addr = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        clear_side_inputs();
        step();
        step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ready", ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        last_rd = '0;

        // Basic load: data equals address.
        base_addr = 16'h0100;
        rst_n     = 1'b1;
        do_load(16'h0100, 1, 1'b1, DEPTH, 1'b0);
        read_entry(5);
        check("basic_entry5", rd_data, 32'h0000_0105);
        work_random(40);

        // Simultaneous read and write to one address returns the old word.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_AAAA;
        step();
        model[3] = 32'h0000_AAAA;
        wr_data = 32'h0000_5555;
        rd_en = 1'b1; rd_addr = 4'd3;
        step();
        clear_side_inputs();
        model[3] = 32'h0000_5555;
        last_rd  = 32'h0000_AAAA;
        check("rw_same_valid", rd_valid, 1);
        check("rw_same_old", rd_data, 32'h0000_AAAA);
        read_entry(3);
        check("rw_same_new", rd_data, 32'h0000_5555);

        // Reload together with a read; then a wrapping load with side traffic.
        exp_d     = model[7];
        base_addr = 16'hFFFE;
        reload = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = $urandom;
        step();
        clear_side_inputs();
        last_rd = exp_d;
        check("reload_rd_valid", rd_valid, 1);
        check("reload_rd_data", rd_data, exp_d);
        check("reload_ready", ready, 0);
        do_load(16'hFFFE, 1, 1'b0, DEPTH, 1'b1);
        read_all();

        // Slow memory: ack every third cycle.
        reload = 1'b1;
        step();
        reload    = 1'b0;
        rbase     = MW'($urandom);
        base_addr = rbase;
        do_load(rbase, 3, 1'b0, DEPTH, 1'b1);
        read_all();

        // Reset in the middle of a load, with an ack in the reset cycle.
        reload = 1'b1;
        base_addr = 16'h2000;
        step();
        reload = 1'b0;
        do_load(16'h2000, 1, 1'b0, 7, 1'b0);
        rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("midrst_mem_req", mem_req, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_ready", ready, 0);
        check("midrst_rd_data", rd_data, 0);
        step();
        check("midrst_mem_req2", mem_req, 0);
        mem_ack   = 1'b0;
        base_addr = 16'h3000;
        rst_n     = 1'b1;
        last_rd   = '0;
        do_load(16'h3000, 1, 1'b1, DEPTH, 1'b0);
        read_all();
        work_random(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
